// File: rtl/mem_mover.sv
// Block-move engine sharing the data memory port with the CPU: copies len bytes src->dst, one byte per READ/WRITE pair.
// Optional MEM_MOVER_FILL_EN adds a fill mode that writes a constant pattern instead of copying.
module mem_mover #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
`ifdef MEM_MOVER_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_val,
`endif
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic [DW-1:0] cpu_wdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done
);

    // state | meaning
    // IDLE  | CPU owns the memory port, waiting for start
    // READ  | fetch byte at src_ptr into data_buf
    // WRITE | store data_buf at dst_ptr, advance pointers
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [AW-1:0] count_q, count_d;
    logic [DW-1:0] data_buf_q, data_buf_d;
`ifdef MEM_MOVER_FILL_EN
    logic          fill_mode_q, fill_mode_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            count_q    <= '0;
            data_buf_q <= '0;
`ifdef MEM_MOVER_FILL_EN
            fill_mode_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            count_q    <= count_d;
            data_buf_q <= data_buf_d;
`ifdef MEM_MOVER_FILL_EN
            fill_mode_q <= fill_mode_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        count_d    = count_q;
        data_buf_d = data_buf_q;
`ifdef MEM_MOVER_FILL_EN
        fill_mode_d = fill_mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        src_ptr_d = src;
                        dst_ptr_d = dst;
                        count_d   = len;
`ifdef MEM_MOVER_FILL_EN
                        fill_mode_d = fill;
                        if (fill) begin
                            data_buf_d = fill_val;
                            state_d    = ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                        end
`else
                        state_d = ST_READ;
`endif
                    end
                end
            end
            ST_READ: begin
                data_buf_d = mem_rdata;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                // Pointers wrap naturally at AW bits.
                src_ptr_d = src_ptr_q + AW'(1);
                dst_ptr_d = dst_ptr_q + AW'(1);
                count_d   = count_q - AW'(1);
                if (count_q == AW'(1)) begin
                    state_d = ST_DONE;
`ifdef MEM_MOVER_FILL_EN
                end else if (fill_mode_q) begin
                    state_d = ST_WRITE;
`endif
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_addr  = cpu_addr;
                mem_read  = cpu_read;
                mem_write = cpu_write;
                mem_wdata = cpu_wdata;
                busy      = 1'b0;
            end
            ST_READ: begin
                mem_addr = src_ptr_q;
                mem_read = 1'b1;
            end
            ST_WRITE: begin
                mem_addr  = dst_ptr_q;
                mem_write = 1'b1;
                mem_wdata = data_buf_q;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_mover.sv
// Self-checking bench for mem_mover: behavioural memory plus a reference memory image updated by plain byte copies.
module tb_mem_mover;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] src = 8'h0, dst = 8'h0, len = 8'h0;
    logic [7:0] cpu_addr = 8'h0, cpu_wdata = 8'h0;
    logic       cpu_read = 1'b0, cpu_write = 1'b0;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_read, mem_write, busy, done;
`ifdef MEM_MOVER_FILL_EN
    logic       fill = 1'b0;
    logic [7:0] fill_val = 8'h0;
`endif

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    mem_mover #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src(src), .dst(dst), .len(len),
`ifdef MEM_MOVER_FILL_EN
        .fill(fill), .fill_val(fill_val),
`endif
        .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_write = 1'b1;
        @(posedge clk); #1;
        cpu_write = 1'b0;
        ref_mem[a] = d;
    endtask

    // mode 0: quiet, 1: random noise on start/cfg/cpu while busy, 2: cpu write 0x05=0x7E while busy
    task automatic do_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input int mode);
        int cyc, busy_n, wr_n, bad_ctl;
        logic [7:0] a, b;
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < l; i++) begin
            a = s + 8'(i);
            b = d + 8'(i);
            ref_mem[b] = ref_mem[a];
        end
        cyc = 1; busy_n = 0; wr_n = 0; bad_ctl = 0;
        while (done !== 1'b1 && cyc < 1000) begin
            if (busy) busy_n++;
            if (mem_write) wr_n++;
            if (mem_write && mem_read) bad_ctl++;
            if (mode == 1) begin
                src = 8'($urandom); dst = 8'($urandom); len = 8'($urandom);
                start = 1'($urandom_range(0, 1));
                cpu_write = 1'($urandom_range(0, 1)); cpu_read = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
            end else if (mode == 2) begin
                cpu_addr = 8'h05; cpu_wdata = 8'h7E; cpu_write = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0;
        check({tag, "_latency"}, cyc, (l == 0) ? 1 : 2 * l + 1);
        check({tag, "_busy_cycles"}, busy_n, 2 * l);
        check({tag, "_writes"}, wr_n, l);
        check({tag, "_rd_wr_overlap"}, bad_ctl, 0);
        check({tag, "_done_ctl"}, {busy, mem_read, mem_write}, 3'b100);
        @(posedge clk); #1;
        check({tag, "_idle_after"}, {busy, done}, 2'b00);
        check_mem({tag, "_mem"});
    endtask

    initial begin
        cpu_addr = 8'h3C; cpu_read = 1'b1;
        #1;
        check("reset_busy_done", {busy, done}, 2'b00);
        check("reset_passthru", {mem_addr, mem_read, mem_write}, {8'h3C, 1'b1, 1'b0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_read = 1'b0;
        #1;
        check("release_passthru", {mem_addr, mem_read}, {8'h3C, 1'b0});

        for (int i = 0; i < 256; i++) cpu_wr(8'(i), 8'($urandom));
        check_mem("preload");

        cpu_wr(8'h10, 8'hA1); cpu_wr(8'h11, 8'hA2); cpu_wr(8'h12, 8'hA3); cpu_wr(8'h13, 8'hA4);
        do_copy("basic4", 8'h10, 8'h40, 8'd4, 0);
        check("basic4_byte3", mem[8'h43], 8'hA4);

        do_copy("len0", 8'h10, 8'h50, 8'd0, 0);

        cpu_wr(8'hFE, 8'h11); cpu_wr(8'hFF, 8'h22); cpu_wr(8'h00, 8'h33);
        do_copy("wrap", 8'hFE, 8'h02, 8'd3, 0);
        check("wrap_byte2", mem[8'h04], 8'h33);

        do_copy("overlap", 8'h30, 8'h31, 8'd5, 0);
        check("overlap_rep", mem[8'h35], mem[8'h30]);

        cpu_wr(8'h05, 8'h00);
        do_copy("cpu_busy", 8'h20, 8'h70, 8'd2, 2);
        check("cpu5_busy", mem[8'h05], 8'h00);
        cpu_wr(8'h05, 8'h7E);
        check("cpu5_idle", mem[8'h05], 8'h7E);

        for (int t = 0; t < 12; t++) begin
            do_copy("rand", 8'($urandom), 8'($urandom), 8'($urandom_range(0, 30)), 1);
        end

        // abort during the WRITE of byte 2
        src = 8'h10; dst = 8'h60; len = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ref_mem[8'h60] = ref_mem[8'h10];
        repeat (3) begin @(posedge clk); #1; end
        check("abort_in_write", {busy, mem_write, mem_addr}, {1'b1, 1'b1, 8'h61});
        rst_n = 1'b0;
        #1;
        check("abort_idle", {busy, done, mem_write}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cpu_addr = 8'h9A; cpu_read = 1'b1;
        #1;
        check("abort_passthru", {mem_addr, mem_read, busy}, {8'h9A, 1'b1, 1'b0});
        cpu_read = 1'b0;
        @(posedge clk); #1;
        check_mem("abort_mem");

`ifdef MEM_MOVER_FILL_EN
        begin
            int cyc, wr_n;
            fill = 1'b1; fill_val = 8'h5A; dst = 8'h80; len = 8'd3; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; fill = 1'b0;
            for (int i = 0; i < 3; i++) ref_mem[8'h80 + 8'(i)] = 8'h5A;
            cyc = 1; wr_n = 0;
            while (done !== 1'b1 && cyc < 100) begin
                if (mem_write) wr_n++;
                @(posedge clk); #1;
                cyc++;
            end
            check("fill_latency", cyc, 4);
            check("fill_writes", wr_n, 3);
            @(posedge clk); #1;
            check_mem("fill_mem");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_mover.md
MEM_MOVER -- requirements
Module: mem_mover

Interface
REQ-001 SHALL have parameter AW, 8, address width of data memory.
REQ-002 SHALL have parameter DW, 8, data width of data memory.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a block move; sampled only in IDLE.
REQ-006 SHALL have ports src, dst, len  input  AW each  source base, destination base, byte count.
REQ-007 SHALL have ports cpu_addr (AW), cpu_read (1), cpu_write (1), cpu_wdata (DW)  input  CPU-side memory request.
REQ-008 SHALL have ports mem_addr (AW), mem_read (1), mem_write (1), mem_wdata (DW)  output  drive data_mem DataAddress/ReadMem/WriteMem/DataIn.
REQ-009 SHALL have port mem_rdata  input  DW  data_mem DataOut; combinational read.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE; CPU stalls on it.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-013 In IDLE, mem_* SHALL equal cpu_* combinationally; busy=0, done=0.
REQ-014 IDLE with start=1 and len!=0 SHALL latch src_ptr=src, dst_ptr=dst, count=len and go to READ.
REQ-015 IDLE with start=1 and len=0 SHALL go to DONE with no memory write.
REQ-016 READ SHALL drive mem_addr=src_ptr, mem_read=1, mem_write=0, capture mem_rdata into buf on the edge, go to WRITE.
REQ-017 WRITE SHALL drive mem_addr=dst_ptr, mem_write=1, mem_wdata=buf; on the edge src_ptr+1, dst_ptr+1, count-1; go to DONE if count==1, else READ.
REQ-018 Pointer increments SHALL wrap modulo 2^AW (0xFF+1=0x00); count is unsigned AW bits.
REQ-019 DONE SHALL assert done=1 for exactly one cycle, mem_read=mem_write=0, then go to IDLE.
REQ-020 Latency: a copy of len=N SHALL pulse done exactly 2N+1 cycles after the start edge; len=0 one cycle after.
REQ-021 Outside IDLE, cpu_* SHALL be ignored; mem_write SHALL never assert in READ or DONE.
REQ-022 start while busy SHALL be ignored, not queued.
REQ-023 Overlapping regions SHALL copy strictly ascending, byte by byte (dst=src+1 replicates the first byte).
REQ-024 src, dst, len changes after the start edge SHALL not affect the transfer in progress.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, buf=0, src_ptr=dst_ptr=count=0.
REQ-026 Reset mid-transfer SHALL abort with no further mem_write; bytes already written remain.
REQ-027 After reset release, mem_* SHALL follow cpu_* in the first cycle.

Configuration
REQ-028 Macro MEM_MOVER_FILL_EN SHALL, when defined, add inputs fill (1) and fill_val (DW); start with fill=1 latches fill_val and skips READ, writing fill_val to dst_ptr each WRITE cycle; N bytes done N+1 cycles after start.
REQ-029 Without MEM_MOVER_FILL_EN, ports fill and fill_val SHALL not exist and only copy mode is supported.

Verification
REQ-030 Preload 0x10..0x13 = 0xA1,0xA2,0xA3,0xA4; start src=0x10 dst=0x40 len=4 -> 0x40..0x43 = A1..A4, done 9 cycles after start, busy high for 8 cycles.
REQ-031 start len=0 -> done one cycle later, no mem_write asserted.
REQ-032 src=0xFE dst=0x02 len=3, preload 0xFE=0x11, 0xFF=0x22, 0x00=0x33 -> 0x02..0x04 = 0x11,0x22,0x33 (wrap).
REQ-033 rst_n low during WRITE of byte 2 of a len=4 copy -> byte 1 written, bytes 2-4 unchanged, busy=0 immediately.
REQ-034 cpu_write addr 0x05 data 0x7E while busy -> 0x05 unchanged; same request in IDLE -> 0x05=0x7E.
REQ-035 With MEM_MOVER_FILL_EN: fill=1 fill_val=0x5A dst=0x80 len=3 -> 0x80..0x82 = 0x5A, done 4 cycles after start.
